gf256_inv: RTL and testbench
============================

GF256_INV -- requirements
Module: gf256_inv

Interface
REQ-001 SHALL have parameter POLY, default 8'h1D, meaning the low 8 bits of the GF(2^8) reduction polynomial x^8+x^4+x^3+x^2+1 (0x11D).
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_resb  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_start  input  1  start request, level-sampled on rising edge of i_clk.
REQ-005 SHALL have port x  input  8  operand, sampled only on an edge where i_start=1.
REQ-006 SHALL have port y  output  8  registered result x^-1 (x^254).
REQ-007 SHALL have port o_ready  output  1  result-valid / idle flag.
REQ-008 SHALL ship companion combinational modules gf256_mult (inputs A[7:0], B[7:0], output X[7:0]) and gf256_sum (inputs a[7:0], b[7:0], output s[7:0]), usable stand-alone.

Function
REQ-009 gf256_sum SHALL compute s = a XOR b, purely combinational.
REQ-010 gf256_mult SHALL compute X = A*B mod (x^8 + POLY), carry-less, purely combinational, zero latency.
REQ-011 gf256_inv SHALL compute y = x^254 by square-and-multiply using gf256_mult instances: acc=1, sq=x^2 at start; then 7 steps of acc<=acc*sq, sq<=sq*sq.
REQ-012 States: IDLE (result held, done=1) and BUSY (step counter 0..6).
REQ-013 Edge with i_start=1, any state: load sq<=x*x, acc<=1, counter<=0, enter BUSY; a start during BUSY aborts and restarts with the new x.
REQ-014 Each BUSY edge with i_start=0 SHALL perform one step; the 7th step writes y<=acc*sq and returns to IDLE.
REQ-015 Latency: y valid and o_ready=1 after exactly 8 rising edges counted from (and including) the start edge, provided i_start is low after the start edge.
REQ-016 o_ready SHALL equal (state==IDLE) AND NOT i_start, combinationally, so it drops in the same cycle i_start rises.
REQ-017 In IDLE, y and o_ready SHALL hold indefinitely (level, not a pulse) until the next start.
REQ-018 y SHALL change only on the final step edge or on reset; intermediate values are not visible on y.
REQ-019 x=0 SHALL yield y=8'h00 with normal latency (no error flag).
REQ-020 i_start held high continuously SHALL keep restarting; o_ready stays 0.
REQ-021 x changes while BUSY SHALL NOT affect the running computation.

Reset
REQ-022 i_resb=0 SHALL asynchronously force IDLE, y=8'h00, counter=0, internal acc/sq=0.
REQ-023 While in reset and after release with i_start=0, o_ready SHALL read 1.
REQ-024 Reset asserted while BUSY SHALL abort the computation; no partial result is ever presented.
REQ-025 First start is accepted on the first rising edge after i_resb deasserts.

Verification
REQ-026 Mult table: A=8'h80,B=8'h02 -> X=8'h1D; A=8'h02,B=8'h8E -> X=8'h01; A=8'h00,B=8'hFF -> X=8'h00; sum a=8'hA5,b=8'h5A -> s=8'hFF.
REQ-027 Start pulse x=8'h02 -> o_ready low same cycle, high after 8 edges, y=8'h8E; x=8'h03 -> y=8'hF4; x=8'h01 -> y=8'h01.
REQ-028 Exhaustive x=1..255 -> gf256_mult(x,y)=8'h01 for every x, latency 8 each; x=0 -> y=8'h00.
REQ-029 Start x=8'h02, then restart at step 3 with x=8'h03 -> y=8'hF4 exactly 8 edges after second start; 8'h8E never appears.
REQ-030 Assert i_resb=0 mid-computation (off-clock-edge) -> y=8'h00, o_ready=1 immediately; i_start held high 5 cycles -> o_ready=0 throughout.

Source files
------------

// File: rtl/gf256_inv.sv
// GF(2^8) inverse y = x^254 by square-and-multiply, plus the
// stand-alone gf256_sum (s=a^b) and gf256_mult (X=A*B) helpers.
//
// gf256_inv ports:
//   i_clk   : clock, rising edge
//   i_resb  : async active-low reset
//   i_start : start request (level, sampled on i_clk)
//   x       : operand, captured on a start edge
//   y       : registered result x^-1 (0 for x=0)
//   o_ready : idle and no start pending

module gf256_sum (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s
);

  assign s = a ^ b;

endmodule

module gf256_mult #(
  parameter logic [7:0] POLY = 8'h1D
) (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] X
);

  logic [7:0] prod;
  logic [7:0] sh;

  // Shift-and-add; each shift of A is reduced
  // immediately so nothing grows past 8 bits.
  always_comb begin
    prod = 8'h00;
    sh   = A;
    for (int i = 0; i < 8; i++) begin
      if (B[i]) prod = prod ^ sh;
      sh = {sh[6:0], 1'b0} ^
           (sh[7] ? POLY : 8'h00);
    end
    X = prod;
  end

endmodule

module gf256_inv #(
  parameter logic [7:0] POLY = 8'h1D
) (
  input  logic       i_clk,
  input  logic       i_resb,
  input  logic       i_start,
  input  logic [7:0] x,
  output logic [7:0] y,
  output logic       o_ready
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] cnt;
  logic [2:0] cnt_nx;
  logic [7:0] acc;
  logic [7:0] acc_nx;
  logic [7:0] sq;
  logic [7:0] sq_nx;
  logic [7:0] y_nx;
  logic [7:0] p_xx;
  logic [7:0] p_as;
  logic [7:0] p_ss;

  gf256_mult #(.POLY(POLY)) u_xx (
    .A(x),
    .B(x),
    .X(p_xx)
  );

  gf256_mult #(.POLY(POLY)) u_as (
    .A(acc),
    .B(sq),
    .X(p_as)
  );

  gf256_mult #(.POLY(POLY)) u_ss (
    .A(sq),
    .B(sq),
    .X(p_ss)
  );

  assign o_ready = (state == IDLE) && !i_start;

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      state <= IDLE;
      cnt   <= 3'd0;
      acc   <= 8'h00;
      sq    <= 8'h00;
      y     <= 8'h00;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      acc   <= acc_nx;
      sq    <= sq_nx;
      y     <= y_nx;
    end
  end

  // After step k, acc = x^(2^(k+2)-2) and
  // sq = x^(2^(k+2)); the last product is x^254.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    acc_nx   = acc;
    sq_nx    = sq;
    y_nx     = y;
    if (i_start) begin
      state_nx = BUSY;
      cnt_nx   = 3'd0;
      acc_nx   = 8'h01;
      sq_nx    = p_xx;
    end else if (state == BUSY) begin
      if (cnt == 3'd6) begin
        y_nx     = p_as;
        state_nx = IDLE;
        cnt_nx   = 3'd0;
      end else begin
        acc_nx = p_as;
        sq_nx  = p_ss;
        cnt_nx = cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_gf256_inv.sv
// Directed bench for gf256_inv, gf256_mult and
// gf256_sum; prints one summary line.

module tb_gf256_inv;

  logic       clk;
  logic       resb;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic       ready;

  logic [7:0] ma;
  logic [7:0] mb;
  logic [7:0] mx;
  logic [7:0] sa;
  logic [7:0] sb;
  logic [7:0] ss;

  int total;
  int bad;

  gf256_inv dut (
    .i_clk(clk),
    .i_resb(resb),
    .i_start(start),
    .x(x),
    .y(y),
    .o_ready(ready)
  );

  gf256_mult u_mult (
    .A(ma),
    .B(mb),
    .X(mx)
  );

  gf256_sum u_sum (
    .a(sa),
    .b(sb),
    .s(ss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11D << (i - 8));
    return p[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_inv(
    input  logic [7:0] v,
    output logic [7:0] res,
    output int         lat
  );
    logic [7:0] prev;
    prev  = y;
    start = 1'b1;
    x     = v;
    #1;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_drop x=%h got=%b want=0",
               v, ready);
    end
    tick();
    start = 1'b0;
    lat   = 1;
    while (ready !== 1'b1 && lat < 20) begin
      total++;
      if (y !== prev) begin
        bad++;
        $display("FAIL y_hold x=%h got=%h want=%h",
                 v, y, prev);
      end
      tick();
      lat++;
    end
    res = y;
  endtask

  task automatic test_reset();
    resb  = 1'b0;
    start = 1'b0;
    x     = 8'h00;
    #12;
    total++;
    if (y !== 8'h00) begin
      bad++;
      $display("FAIL rst_y got=%h want=00", y);
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready got=%b want=1", ready);
    end
    #2 resb = 1'b1;
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL rel_ready got=%b want=1", ready);
    end
  endtask

  task automatic test_mult_table();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [7:0] vx [4];
    va = '{8'h80, 8'h02, 8'h00, 8'h57};
    vb = '{8'h02, 8'h8E, 8'hFF, 8'h01};
    vx = '{8'h1D, 8'h01, 8'h00, 8'h57};
    for (int i = 0; i < 4; i++) begin
      ma = va[i];
      mb = vb[i];
      #1;
      total++;
      if (mx !== vx[i]) begin
        bad++;
        $display("FAIL mult %h*%h got=%h want=%h",
                 ma, mb, mx, vx[i]);
      end
    end
    sa = 8'hA5;
    sb = 8'h5A;
    #1;
    total++;
    if (ss !== 8'hFF) begin
      bad++;
      $display("FAIL sum got=%h want=FF", ss);
    end
  endtask

  task automatic test_directed();
    logic [7:0] vi [4];
    logic [7:0] vo [4];
    logic [7:0] r;
    int         lat;
    vi = '{8'h02, 8'h03, 8'h01, 8'h00};
    vo = '{8'h8E, 8'hF4, 8'h01, 8'h00};
    for (int i = 0; i < 4; i++) begin
      do_inv(vi[i], r, lat);
      total++;
      if (r !== vo[i]) begin
        bad++;
        $display("FAIL inv x=%h got=%h want=%h",
                 vi[i], r, vo[i]);
      end
      total++;
      if (lat != 8) begin
        bad++;
        $display("FAIL lat x=%h got=%0d want=8",
                 vi[i], lat);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] r;
    int         lat;
    for (int v = 1; v < 256; v++) begin
      do_inv(8'(v), r, lat);
      total++;
      if (gmul(8'(v), r) !== 8'h01) begin
        bad++;
        $display("FAIL exh x=%h y=%h prod=%h want=01",
                 8'(v), r, gmul(8'(v), r));
      end
      total++;
      if (lat != 8) begin
        bad++;
        $display("FAIL exh_lat x=%h got=%0d want=8",
                 8'(v), lat);
      end
    end
  endtask

  task automatic test_restart();
    logic [7:0] r;
    int         lat;
    do_inv(8'h00, r, lat);
    start = 1'b1;
    x     = 8'h02;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    start = 1'b1;
    x     = 8'h03;
    tick();
    start = 1'b0;
    lat   = 1;
    while (ready !== 1'b1 && lat < 20) begin
      total++;
      if (y === 8'h8E) begin
        bad++;
        $display("FAIL rs_leak got=%h want!=8E", y);
      end
      tick();
      lat++;
    end
    total++;
    if (y !== 8'hF4) begin
      bad++;
      $display("FAIL rs_y got=%h want=F4", y);
    end
    total++;
    if (lat != 8) begin
      bad++;
      $display("FAIL rs_lat got=%0d want=8", lat);
    end
  endtask

  task automatic test_x_change();
    logic [7:0] r;
    int         lat;
    start = 1'b1;
    x     = 8'h02;
    tick();
    start = 1'b0;
    lat   = 1;
    while (ready !== 1'b1 && lat < 20) begin
      x = 8'($urandom_range(0, 255));
      tick();
      lat++;
    end
    r = y;
    total++;
    if (r !== 8'h8E) begin
      bad++;
      $display("FAIL xchg_y got=%h want=8E", r);
    end
    total++;
    if (lat != 8) begin
      bad++;
      $display("FAIL xchg_lat got=%0d want=8", lat);
    end
  endtask

  task automatic test_reset_busy();
    start = 1'b1;
    x     = 8'h03;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 resb = 1'b0;
    #1;
    total++;
    if (y !== 8'h00) begin
      bad++;
      $display("FAIL rb_y got=%h want=00", y);
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL rb_ready got=%b want=1", ready);
    end
    tick();
    tick();
    #2 resb = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      total++;
      if (y !== 8'h00 || ready !== 1'b1) begin
        bad++;
        $display("FAIL rb_after y=%h rdy=%b want=00/1",
                 y, ready);
      end
    end
  endtask

  task automatic test_start_held();
    int lat;
    start = 1'b1;
    x     = 8'h03;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (ready !== 1'b0 || y !== 8'h00) begin
        bad++;
        $display("FAIL held c%0d rdy=%b y=%h want=0/00",
                 i, ready, y);
      end
      tick();
    end
    start = 1'b0;
    lat   = 1;
    while (ready !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    total++;
    if (y !== 8'hF4 || lat != 8) begin
      bad++;
      $display("FAIL held_res y=%h lat=%0d want=F4/8",
               y, lat);
    end
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (y !== 8'hF4 || ready !== 1'b1) begin
        bad++;
        $display("FAIL idle y=%h rdy=%b want=F4/1",
                 y, ready);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ma    = 8'h00;
    mb    = 8'h00;
    sa    = 8'h00;
    sb    = 8'h00;
    test_reset();
    test_directed();
    test_mult_table();
    test_exhaustive();
    test_restart();
    test_x_change();
    test_reset_busy();
    test_start_held();
    test_idle_hold();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
